// File: rtl/pipe_pkg.sv
// Shared types and sizing helpers for the jump redirect controller.
// Holds the controller state encoding, datapath defaults and flush counter sizing.
package pipe_pkg;

    localparam int XLEN_DEF         = 32;
    localparam int FLUSH_CYCLES_DEF = 2;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_RS1 = 2'd1,
        FLUSH    = 2'd2
    } state_e;

    function automatic int clog2(input int value);
        int w;
        w = 0;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        return w;
    endfunction

    // The flush counter must be able to hold FLUSH_CYCLES itself, hence the +1.
    function automatic int flush_cnt_width(input int flush_cycles);
        return clog2(flush_cycles + 1);
    endfunction

endpackage

// File: rtl/jump_target_calc.sv
// Combinational jump target / link value computation for jal and jalr.
// Produces the target, the return address (pc+4) and a misaligned-target flag.
module jump_target_calc
    import pipe_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic            is_jalr_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] imm_i,
    input  logic [XLEN-1:0] rs1_val_i,
    output logic [XLEN-1:0] target_o,
    output logic [XLEN-1:0] link_o,
    output logic            misalign_o
);

    logic [XLEN-1:0] base;
    logic [XLEN-1:0] sum;

    assign base = is_jalr_i ? rs1_val_i : pc_i;
    assign sum  = base + imm_i;

    // jalr always clears bit 0 of the target; jal uses the raw sum.
    assign target_o   = is_jalr_i ? {sum[XLEN-1:1], 1'b0} : sum;
    assign link_o     = pc_i + XLEN'(4);
    assign misalign_o = target_o[1];

endmodule

// File: rtl/jump_redirect_ctrl.sv
// Jump redirect controller: accepts jal/jalr, redirects fetch, flushes upstream stages.
// Optional JUMP_MISALIGN_TRAP_EN turns misaligned targets into a trap pulse instead of a redirect.
module jump_redirect_ctrl
    import pipe_pkg::*;
#(
    parameter int XLEN         = XLEN_DEF,
    parameter int FLUSH_CYCLES = FLUSH_CYCLES_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            jal_in,
    input  logic            jalr_in,
    input  logic [XLEN-1:0] pc_in,
    input  logic [XLEN-1:0] imm_in,
    input  logic [XLEN-1:0] rs1_val,
    input  logic            rs1_ready,
    input  logic            stall_in,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            link_valid,
    output logic [XLEN-1:0] link_data,
    output logic            flush_ir,
    output logic            hold_pc,
    output logic            misalign_trap
);

    localparam int CW = flush_cnt_width(FLUSH_CYCLES);

`ifdef JUMP_MISALIGN_TRAP_EN
    localparam logic TRAP_EN = 1'b1;
`else
    localparam logic TRAP_EN = 1'b0;
`endif

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] pc_lat_q, pc_lat_d;
    logic [XLEN-1:0] imm_lat_q, imm_lat_d;
    logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
    logic [XLEN-1:0] link_data_q, link_data_d;
    logic            redirect_valid_q, redirect_valid_d;
    logic            link_valid_q, link_valid_d;
    logic            trap_q, trap_d;

    logic            accept;
    logic            calc_jalr;
    logic [XLEN-1:0] calc_pc;
    logic [XLEN-1:0] calc_imm;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] link;
    logic            misalign;
    logic            trap_hit;

    // While waiting on rs1 the calculator works from the latched jalr operands.
    always_comb begin
        calc_jalr = jalr_in;
        calc_pc   = pc_in;
        calc_imm  = imm_in;
        if (state_q == WAIT_RS1) begin
            calc_jalr = 1'b1;
            calc_pc   = pc_lat_q;
            calc_imm  = imm_lat_q;
        end
    end

    jump_target_calc #(
        .XLEN(XLEN)
    ) u_calc (
        .is_jalr_i (calc_jalr),
        .pc_i      (calc_pc),
        .imm_i     (calc_imm),
        .rs1_val_i (rs1_val),
        .target_o  (target),
        .link_o    (link),
        .misalign_o(misalign)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pc_lat_d  = pc_lat_q;
        imm_lat_d = imm_lat_q;
        accept    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!stall_in) begin
                    if (jalr_in) begin
                        if (rs1_ready) begin
                            accept = 1'b1;
                        end else begin
                            pc_lat_d  = pc_in;
                            imm_lat_d = imm_in;
                            state_d   = WAIT_RS1;
                        end
                    end else if (jal_in) begin
                        accept = 1'b1;
                    end
                end
            end
            WAIT_RS1: begin
                if (rs1_ready) begin
                    accept = 1'b1;
                end
            end
            FLUSH: begin
                if (!stall_in) begin
                    if (cnt_q <= CW'(1)) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        if (accept) begin
            state_d = FLUSH;
            cnt_d   = CW'(FLUSH_CYCLES);
        end
    end

    // A trapped jump still counts as accepted: it flushes and updates the held target.
    always_comb begin
        trap_hit         = TRAP_EN & misalign;
        redirect_valid_d = accept & ~trap_hit;
        link_valid_d     = accept & ~trap_hit;
        trap_d           = accept & trap_hit;
        redirect_pc_d    = accept ? target : redirect_pc_q;
        link_data_d      = accept ? link : link_data_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q          <= IDLE;
            cnt_q            <= '0;
            pc_lat_q         <= '0;
            imm_lat_q        <= '0;
            redirect_pc_q    <= '0;
            link_data_q      <= '0;
            redirect_valid_q <= 1'b0;
            link_valid_q     <= 1'b0;
            trap_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            pc_lat_q         <= pc_lat_d;
            imm_lat_q        <= imm_lat_d;
            redirect_pc_q    <= redirect_pc_d;
            link_data_q      <= link_data_d;
            redirect_valid_q <= redirect_valid_d;
            link_valid_q     <= link_valid_d;
            trap_q           <= trap_d;
        end
    end

    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign link_valid     = link_valid_q;
    assign link_data      = link_data_q;
    assign misalign_trap  = trap_q;
    assign flush_ir       = (state_q == FLUSH);
    assign hold_pc        = (state_q == WAIT_RS1);

endmodule
